// File: rtl/nvram_seq_pkg.sv
// Shared state codes, access modes and default FM1808 timing for the NVRAM cycle sequencer.
// Pure constants; no logic, latency or backpressure of its own.
package nvram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_HOLD      = 3'd3,
    S_PRECHARGE = 3'd4
  } seq_state_t;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

  // At 16 MHz one cycle is 62.5 ns, so single-cycle setup/hold margins cover FM1808 timing.
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_T_SETUP     = 1;
  localparam int DEF_T_HOLD      = 1;
  localparam int DEF_T_PRECHARGE = 2;
  localparam int DEF_MAX_EXTEND  = 15;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with hold and a registered zero flag; load/decrement take effect next edge.
// No backpressure: hold freezes the count, load overrides hold.
module phase_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (!hold && (count != '0)) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/nvram_cycle_sequencer.sv
// /CE,/WE,/OE cycle sequencer: Done lands T_SETUP+D+T_HOLD+T_PRECHARGE+stalls edges after Start.
// Extend stalls ACCESS up to MAX_EXTEND edges, then the cycle is forced to HOLD and Error flags it.
module nvram_cycle_sequencer
  import nvram_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_PRECHARGE = DEF_T_PRECHARGE,
  parameter int MAX_EXTEND  = DEF_MAX_EXTEND
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ReadSeq,
  input  logic             WriteSeq,
  input  logic             Extend,
  input  logic [CNT_W-1:0] Delay,
  output logic             CE,
  output logic             WE,
  output logic             OE,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [2:0]       SeqState
);

  // Counters hold "cycles remaining minus one" so the zero flag marks the last cycle of a phase.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(T_PRECHARGE - 1);
  localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(MAX_EXTEND - 1);

  seq_state_t       state, state_nx;
  logic             mode, mode_nx;
  logic [CNT_W-1:0] acc_len, acc_nx;
  logic             timeout, to_nx;
  logic             done_nx, err_nx;
  logic             ph_load, ph_hold, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             st_load, st_hold, st_zero;

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk(Clk), .rst(Reset), .load(ph_load), .load_val(ph_val), .hold(ph_hold), .zero(ph_zero)
  );

  phase_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(Clk), .rst(Reset), .load(st_load), .load_val(STALL_LD), .hold(st_hold), .zero(st_zero)
  );

  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    acc_nx   = acc_len;
    to_nx    = timeout;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    ph_load  = 1'b0;
    ph_val   = '0;
    ph_hold  = 1'b1;
    st_load  = 1'b0;
    st_hold  = 1'b1;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (ReadSeq ^ WriteSeq) begin
            state_nx = S_SETUP;
            mode_nx  = WriteSeq ? MODE_WR : MODE_RD;
            acc_nx   = (Delay == '0) ? '0 : Delay - CNT_W'(1);
            to_nx    = 1'b0;
            ph_load  = 1'b1;
            ph_val   = SETUP_LD;
            st_load  = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (ph_zero) begin
          state_nx = S_ACCESS;
          ph_load  = 1'b1;
          ph_val   = acc_len;
        end else begin
          ph_hold = 1'b0;
        end
      end
      S_ACCESS: begin
        // A stalled edge never advances the access count.
        if (Extend) begin
          if (st_zero) begin
            state_nx = S_HOLD;
            to_nx    = 1'b1;
            ph_load  = 1'b1;
            ph_val   = HOLD_LD;
          end else begin
            st_hold = 1'b0;
          end
        end else if (ph_zero) begin
          state_nx = S_HOLD;
          ph_load  = 1'b1;
          ph_val   = HOLD_LD;
        end else begin
          ph_hold = 1'b0;
        end
      end
      S_HOLD: begin
        if (ph_zero) begin
          state_nx = S_PRECHARGE;
          ph_load  = 1'b1;
          ph_val   = PRE_LD;
        end else begin
          ph_hold = 1'b0;
        end
      end
      S_PRECHARGE: begin
        if (ph_zero) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
          err_nx   = timeout;
        end else begin
          ph_hold = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they change on the same edge as SeqState.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      mode     <= MODE_RD;
      acc_len  <= '0;
      timeout  <= 1'b0;
      CE       <= 1'b1;
      WE       <= 1'b1;
      OE       <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      SeqState <= 3'd0;
    end else begin
      state    <= state_nx;
      mode     <= mode_nx;
      acc_len  <= acc_nx;
      timeout  <= to_nx;
      CE       <= !((state_nx == S_SETUP) || (state_nx == S_ACCESS) || (state_nx == S_HOLD));
      WE       <= !((state_nx == S_ACCESS) && (mode_nx == MODE_WR));
      OE       <= !((state_nx == S_ACCESS) && (mode_nx == MODE_RD));
      Busy     <= (state_nx != S_IDLE);
      Done     <= done_nx;
      Error    <= err_nx;
      SeqState <= state_nx;
    end
  end

endmodule

// File: tb/tb_nvram_cycle_sequencer.sv
// Randomized bench for nvram_cycle_sequencer; expected waveforms are derived from phase-length
// arithmetic (setup, access edges incl. stalls, hold, precharge) computed before each cycle starts.
module tb_nvram_cycle_sequencer;

  localparam int CNT_W = 4;
  localparam int TS    = 1;
  localparam int TH    = 1;
  localparam int TP    = 2;
  localparam int MAXE  = 15;

  logic             Clk = 1'b0;
  logic             Reset, Start, ReadSeq, WriteSeq, Extend;
  logic [CNT_W-1:0] Delay;
  logic             CE, WE, OE, Busy, Done, Error;
  logic [2:0]       SeqState;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  nvram_cycle_sequencer #(
    .CNT_W(CNT_W), .T_SETUP(TS), .T_HOLD(TH), .T_PRECHARGE(TP), .MAX_EXTEND(MAXE)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ReadSeq(ReadSeq), .WriteSeq(WriteSeq),
    .Extend(Extend), .Delay(Delay), .CE(CE), .WE(WE), .OE(OE), .Busy(Busy),
    .Done(Done), .Error(Error), .SeqState(SeqState)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_pins(input string tag, input bit ce, input bit we, input bit oe,
                            input bit busy, input bit done, input bit err, input int st);
    check_eq({tag, ".CE"}, 32'(CE), 32'(ce));
    check_eq({tag, ".WE"}, 32'(WE), 32'(we));
    check_eq({tag, ".OE"}, 32'(OE), 32'(oe));
    check_eq({tag, ".Busy"}, 32'(Busy), 32'(busy));
    check_eq({tag, ".Done"}, 32'(Done), 32'(done));
    check_eq({tag, ".Error"}, 32'(Error), 32'(err));
    check_eq({tag, ".SeqState"}, 32'(SeqState), 32'(st));
  endtask

  // ext_kind: 0 none, 1 sparse random, 2 four-cycle burst mid-access, 3 held high
  task automatic run_cycle(input string tag, input bit wr, input int dly, input int ext_kind);
    bit ext_plan[64];
    int dd, a, stalls, prog, total, st;
    bit to;
    dd = (dly == 0) ? 1 : dly;
    for (int k = 0; k < 64; k++) begin
      case (ext_kind)
        1:       ext_plan[k] = ($urandom_range(0, 3) == 0);
        2:       ext_plan[k] = (k >= TS + 2) && (k < TS + 6);
        3:       ext_plan[k] = 1'b1;
        default: ext_plan[k] = 1'b0;
      endcase
    end
    // Edge N+k is driven by ext_plan[k]; access edges are N+TS+1 .. N+TS+a.
    a = 0; stalls = 0; prog = 0; to = 1'b0;
    for (int j = 0; j < 40; j++) begin
      a++;
      if (ext_plan[TS + a]) begin
        stalls++;
        if (stalls == MAXE) begin
          to = 1'b1;
          break;
        end
      end else begin
        prog++;
        if (prog == dd) break;
      end
    end
    total = TS + a + TH + TP;

    Start = 1'b1; ReadSeq = !wr; WriteSeq = wr; Delay = CNT_W'(dly); Extend = 1'($urandom);
    for (int k = 0; k <= total; k++) begin
      if (k > 0) begin
        // Requests while busy must be ignored.
        Extend = ext_plan[k]; Start = 1'($urandom); ReadSeq = 1'($urandom);
        WriteSeq = 1'($urandom); Delay = CNT_W'($urandom);
      end
      tick();
      if (k < TS)               st = 1;
      else if (k < TS + a)      st = 2;
      else if (k < TS + a + TH) st = 3;
      else if (k < total)       st = 4;
      else                      st = 0;
      check_pins(tag, !(st >= 1 && st <= 3), !(st == 2 && wr), !(st == 2 && !wr),
                 st != 0, k == total, (k == total) && to, st);
    end
    Start = 1'b0; Extend = 1'b0;
    tick();
    check_pins({tag, ".after"}, 1, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic illegal_req(input string tag, input bit rd, input bit wrs);
    Start = 1'b1; ReadSeq = rd; WriteSeq = wrs; Delay = CNT_W'($urandom); Extend = 1'($urandom);
    tick();
    check_pins(tag, 1, 1, 1, 0, 0, 1, 0);
    Start = 1'b0;
    tick();
    check_pins({tag, ".next"}, 1, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ReadSeq = 1'b0; WriteSeq = 1'b0; Extend = 1'b0; Delay = '0;
    tick();
    tick();
    check_pins("reset", 1, 1, 1, 0, 0, 0, 0);
    Reset = 1'b0;
    tick();

    run_cycle("rd_d3", 1'b0, 3, 0);
    run_cycle("wr_d0", 1'b1, 0, 0);
    run_cycle("rd_d2_ext4", 1'b0, 2, 2);
    run_cycle("wr_ext_perm", 1'b1, 5, 3);
    illegal_req("ill_both", 1'b1, 1'b1);
    illegal_req("ill_none", 1'b0, 1'b0);

    // Reset in the middle of a write access.
    Start = 1'b1; ReadSeq = 1'b0; WriteSeq = 1'b1; Delay = CNT_W'(6);
    tick();
    Start = 1'b0;
    for (int k = 0; k < TS + 1; k++) tick();
    check_eq("mid.SeqState", 32'(SeqState), 32'd2);
    check_eq("mid.WE", 32'(WE), 32'd0);
    Reset = 1'b1;
    tick();
    check_pins("rst_mid", 1, 1, 1, 0, 0, 0, 0);
    Reset = 1'b0;
    tick();
    check_pins("rst_mid.next", 1, 1, 1, 0, 0, 0, 0);
    run_cycle("post_rst", 1'b0, 4, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) illegal_req("rnd_ill_both", 1'b1, 1'b1);
        else                           illegal_req("rnd_ill_none", 1'b0, 1'b0);
      end
      run_cycle("rnd", 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
